// File: rtl/buzz_scheduler.sv
// Shares one piezo buzzer between three alert sources, playing each source's
// fixed on/off beep pattern by fixed priority and pulsing done on completion.
module buzz_scheduler #(
  parameter int unsigned UNIT_CYC = 5_000_000,
  parameter int unsigned TONE_DIV = 12_500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  output logic       buzzer,
  output logic [2:0] grant,
  output logic       busy,
  output logic [2:0] done
);

  localparam int unsigned DW = $clog2(4 * UNIT_CYC + 1);
  localparam int unsigned TW = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;

  // Duration counters are loaded with length-1 and count down to zero.
  localparam logic [DW-1:0] ERR_ON  = DW'(1 * UNIT_CYC - 1);
  localparam logic [DW-1:0] ERR_OFF = DW'(1 * UNIT_CYC - 1);
  localparam logic [DW-1:0] ARR_ON  = DW'(4 * UNIT_CYC - 1);
  localparam logic [DW-1:0] ARR_OFF = DW'(1 * UNIT_CYC - 1);
  localparam logic [DW-1:0] EOT_ON  = DW'(2 * UNIT_CYC - 1);
  localparam logic [DW-1:0] EOT_OFF = DW'(2 * UNIT_CYC - 1);
  localparam logic [TW-1:0] TONE_LAST = TW'(TONE_DIV - 1);

  typedef enum logic [2:0] {IDLE, ARB, ON, OFF, DONE} state_t;

  state_t        state_q, state_d;
  logic [2:0]    req_q, pending, pending_d, rise, pick;
  logic [2:0]    grant_d, done_d;
  logic          buzzer_d, busy_d;
  logic [1:0]    rep_cnt, rep_d;
  logic [DW-1:0] dur_cnt, dur_d, on_ld, on_d, off_ld, off_d;
  logic [TW-1:0] tone_cnt, tone_d;

  function automatic logic [2:0] lowest_bit(input logic [2:0] v);
    return v & (~v + 3'd1);
  endfunction

  assign rise = req & ~req_q;
  assign pick = lowest_bit(pending);

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    pending_d = pending | rise;
    grant_d   = grant;
    buzzer_d  = 1'b0;
    done_d    = 3'b000;
    rep_d     = rep_cnt;
    dur_d     = dur_cnt;
    tone_d    = tone_cnt;
    on_d      = on_ld;
    off_d     = off_ld;

    unique case (state_q)
      IDLE: begin
        if (pending != 3'b000) begin
          state_d   = ARB;
          grant_d   = pick;
          pending_d = (pending & ~pick) | rise;
        end
      end
      ARB: begin
        case (grant)
          3'b001:  begin on_d = ERR_ON; off_d = ERR_OFF; rep_d = 2'd3; end
          3'b010:  begin on_d = ARR_ON; off_d = ARR_OFF; rep_d = 2'd1; end
          default: begin on_d = EOT_ON; off_d = EOT_OFF; rep_d = 2'd2; end
        endcase
        state_d  = ON;
        dur_d    = on_d;
        buzzer_d = 1'b1;
        tone_d   = '0;
      end
      ON: begin
        buzzer_d = buzzer;
        if (tone_cnt == TONE_LAST) begin
          buzzer_d = ~buzzer;
          tone_d   = '0;
        end else begin
          tone_d = tone_cnt + TW'(1);
        end
        if (dur_cnt == '0) begin
          state_d  = OFF;
          dur_d    = off_ld;
          buzzer_d = 1'b0;
        end else begin
          dur_d = dur_cnt - DW'(1);
        end
      end
      OFF: begin
        if (dur_cnt == '0) begin
          rep_d = rep_cnt - 2'd1;
          if (rep_cnt == 2'd1) begin
            state_d = DONE;
            done_d  = grant;
          end else begin
            state_d  = ON;
            dur_d    = on_ld;
            buzzer_d = 1'b1;
            tone_d   = '0;
          end
        end else begin
          dur_d = dur_cnt - DW'(1);
        end
      end
      DONE: begin
        grant_d = 3'b000;
        if (pending != 3'b000) begin
          state_d   = ARB;
          grant_d   = pick;
          pending_d = (pending & ~pick) | rise;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the values computed in the previous cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      req_q    <= 3'b000;
      pending  <= 3'b000;
      grant    <= 3'b000;
      buzzer   <= 1'b0;
      busy     <= 1'b0;
      done     <= 3'b000;
      rep_cnt  <= 2'd0;
      dur_cnt  <= '0;
      tone_cnt <= '0;
      on_ld    <= '0;
      off_ld   <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= req;
      pending  <= pending_d;
      grant    <= grant_d;
      buzzer   <= buzzer_d;
      busy     <= busy_d;
      done     <= done_d;
      rep_cnt  <= rep_d;
      dur_cnt  <= dur_d;
      tone_cnt <= tone_d;
      on_ld    <= on_d;
      off_ld   <= off_d;
    end
  end

endmodule

// File: tb/tb_buzz_scheduler.sv
// Directed bench for buzz_scheduler with UNIT_CYC=10, TONE_DIV=2; expected
// waveforms are derived from the pattern table and cycle latencies.
module tb_buzz_scheduler;

  localparam int UNIT = 10;
  localparam int TDIV = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] req;
  logic       buzzer;
  logic [2:0] grant;
  logic       busy;
  logic [2:0] done;

  int n_cmp = 0;
  int n_err = 0;

  buzz_scheduler #(.UNIT_CYC(UNIT), .TONE_DIV(TDIV)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .buzzer (buzzer),
    .grant  (grant),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Checks one full pattern starting at the first ON edge; ends sampled at DONE.
  task automatic expect_pattern(input logic [2:0] g, input int on_u, input int off_u,
                                input int reps);
    for (int r = 0; r < reps; r++) begin
      for (int c = 0; c < on_u * UNIT; c++) begin
        step();
        check("on_buzzer", buzzer, ((c / TDIV) % 2 == 0) ? 1 : 0);
        check("on_grant", grant, g);
        check("on_done", done, 0);
      end
      for (int c = 0; c < off_u * UNIT; c++) begin
        step();
        check("off_buzzer", buzzer, 0);
        check("off_done", done, 0);
        check("off_busy", busy, 1);
      end
    end
    step();
    check("done_pulse", done, g);
    check("done_buzzer", buzzer, 0);
    check("done_grant", grant, g);
  endtask

  task automatic expect_arb(input logic [2:0] g);
    step();
    check("arb_grant", grant, g);
    check("arb_busy", busy, 1);
    check("arb_buzzer", buzzer, 0);
    check("arb_done", done, 0);
  endtask

  task automatic expect_idle(input string tag);
    step();
    check({tag, "_busy"}, busy, 0);
    check({tag, "_grant"}, grant, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_buzzer"}, buzzer, 0);
  endtask

  initial begin
    rst = 1'b0;
    req = 3'b000;
    #2;
    check("rst_buzzer", buzzer, 0);
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    expect_idle("post_rst");

    // Arrival: edge 0 capture, edge 1 ARB, edge 2 first ON, done at edge 52.
    req = 3'b010;
    step();
    check("arr_e0_busy", busy, 0);
    check("arr_e0_grant", grant, 0);
    expect_arb(3'b010);
    expect_pattern(3'b010, 4, 1, 1);
    expect_idle("arr_end");
    req = 3'b000;
    repeat (3) expect_idle("arr_quiet");

    // Error: single-cycle pulse.
    req = 3'b001;
    step();
    req = 3'b000;
    expect_arb(3'b001);
    expect_pattern(3'b001, 1, 1, 3);
    expect_idle("err_end");

    // Simultaneous error and end-of-track: DONE goes straight to ARB.
    req = 3'b101;
    step();
    req = 3'b000;
    expect_arb(3'b001);
    expect_pattern(3'b001, 1, 1, 3);
    expect_arb(3'b100);
    expect_pattern(3'b100, 2, 2, 2);
    expect_idle("sim_end");

    // Held end-of-track for 200 cycles plays once.
    req = 3'b100;
    step();
    expect_arb(3'b100);
    expect_pattern(3'b100, 2, 2, 2);
    for (int i = 0; i < 200 - 83; i++) expect_idle("held");
    req = 3'b000;
    repeat (3) expect_idle("held_rel");

    // Re-queue of arrival plus a higher-priority request mid-pattern.
    req = 3'b010;
    step();
    expect_arb(3'b010);
    fork
      expect_pattern(3'b010, 4, 1, 1);
      begin
        repeat (5) step();
        req = 3'b000;
        repeat (3) step();
        req = 3'b011;
      end
    join
    expect_arb(3'b001);
    expect_pattern(3'b001, 1, 1, 3);
    expect_arb(3'b010);
    expect_pattern(3'b010, 4, 1, 1);
    expect_idle("rq_end");
    req = 3'b000;
    repeat (3) expect_idle("rq_quiet");

    // Reset mid-ON: immediate silence, no done, no replay.
    req = 3'b010;
    step();
    expect_arb(3'b010);
    repeat (15) step();
    check("pre_rst_busy", busy, 1);
    rst = 1'b0;
    req = 3'b000;
    #2;
    check("midrst_buzzer", buzzer, 0);
    check("midrst_grant", grant, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    for (int i = 0; i < 80; i++) expect_idle("no_replay");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
